// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS segment sequencer: form codes,
// sequencer state encoding and the segment table entry layout.
package dds_pkg;

    localparam int SEG_CNT_W = 16;

    localparam logic [2:0] FORM_SAW       = 3'b000;
    localparam logic [2:0] FORM_RSAW      = 3'b001;
    localparam logic [2:0] FORM_TRI       = 3'b010;
    localparam logic [2:0] FORM_MEANDER   = 3'b011;
    localparam logic [2:0] FORM_MEANDER25 = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [2:0]           form;
        logic [31:0]          adder;
        logic [SEG_CNT_W-1:0] count;
    } seg_t;

    // Reserved codes are kept in the table but must never reach the form block.
    function automatic logic [2:0] form_drive(input logic [2:0] code);
        return (code > FORM_MEANDER25) ? FORM_SAW : code;
    endfunction

endpackage

// File: rtl/dds_seg_table.sv
// Segment table: DEPTH entries, synchronous write, combinational read,
// cleared asynchronously whenever reset is asserted.
module dds_seg_table
    import dds_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  seg_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output seg_t          rd_data
);

    seg_t mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/dds_seq_ctrl.sv
// Plays a table of {form, tuning word, period count} segments into the DDS
// datapath, switching segments only on accumulator phase wraps.
module dds_seq_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             WR_EN,
    input  logic [AW-1:0]    WR_ADDR,
    input  logic [2:0]       WR_FORM,
    input  logic [31:0]      WR_ADDER,
    input  logic [CNT_W-1:0] WR_COUNT,
    input  logic [AW-1:0]    SEG_LAST,
    input  logic             LOOP,
    input  logic             START,
    input  logic             STOP,
    input  logic             PHASE_WRAP,
    output logic [31:0]      ADDER,
    output logic [2:0]       FORM,
    output logic             UPDATE,
    output logic             BUSY,
    output logic             DONE,
    output logic [AW-1:0]    SEG_IDX
);

    import dds_pkg::*;

    state_t           state_q, state_d;
    logic [31:0]      adder_q, adder_d;
    logic [2:0]       form_q, form_d;
    logic             update_q, update_d;
    logic [AW-1:0]    seg_idx_q, seg_idx_d;
    logic [AW-1:0]    seg_last_q, seg_last_d;
    logic             loop_q, loop_d;
    logic [CNT_W-1:0] remain_q, remain_d;

    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    next_idx;
    logic [CNT_W-1:0] load_cnt;
    seg_t             wr_seg;
    seg_t             rd_seg;

    assign wr_seg = '{form: WR_FORM, adder: WR_ADDER, count: WR_COUNT};

    dds_seg_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .wr_en   (WR_EN && (state_q != ST_RUN)),
        .wr_addr (WR_ADDR),
        .wr_data (wr_seg),
        .rd_addr (rd_addr),
        .rd_data (rd_seg)
    );

    // A zero count would never expire, so it plays for a single period.
    assign load_cnt = (rd_seg.count == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : rd_seg.count;
    assign next_idx = (seg_idx_q == seg_last_q) ? '0 : seg_idx_q + 1'b1;
    assign rd_addr  = (state_q == ST_RUN) ? next_idx : '0;

    always_comb begin
        state_d    = state_q;
        adder_d    = adder_q;
        form_d     = form_q;
        update_d   = 1'b0;
        seg_idx_d  = seg_idx_q;
        seg_last_d = seg_last_q;
        loop_d     = loop_q;
        remain_d   = remain_q;

        if (STOP) begin
            state_d   = ST_IDLE;
            adder_d   = '0;
            form_d    = FORM_SAW;
            seg_idx_d = '0;
            update_d  = (state_q != ST_IDLE);
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        state_d    = ST_RUN;
                        seg_last_d = SEG_LAST;
                        loop_d     = LOOP;
                        seg_idx_d  = '0;
                        adder_d    = rd_seg.adder;
                        form_d     = form_drive(rd_seg.form);
                        remain_d   = load_cnt;
                        update_d   = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (PHASE_WRAP) begin
                        if (remain_q > 1) begin
                            remain_d = remain_q - 1'b1;
                        end else if ((seg_idx_q != seg_last_q) || loop_q) begin
                            seg_idx_d = next_idx;
                            adder_d   = rd_seg.adder;
                            form_d    = form_drive(rd_seg.form);
                            remain_d  = load_cnt;
                            update_d  = 1'b1;
                        end else begin
                            state_d  = ST_DONE;
                            adder_d  = '0;
                            update_d = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            adder_q    <= '0;
            form_q     <= FORM_SAW;
            update_q   <= 1'b0;
            seg_idx_q  <= '0;
            seg_last_q <= '0;
            loop_q     <= 1'b0;
            remain_q   <= '0;
        end else begin
            state_q    <= state_d;
            adder_q    <= adder_d;
            form_q     <= form_d;
            update_q   <= update_d;
            seg_idx_q  <= seg_idx_d;
            seg_last_q <= seg_last_d;
            loop_q     <= loop_d;
            remain_q   <= remain_d;
        end
    end

    assign ADDER   = adder_q;
    assign FORM    = form_q;
    assign UPDATE  = update_q;
    assign BUSY    = (state_q == ST_RUN);
    assign DONE    = (state_q == ST_DONE);
    assign SEG_IDX = seg_idx_q;

endmodule

// File: tb/tb_dds_seq_ctrl.sv
// Directed and randomized checks of dds_seq_ctrl against a slot-list model
// of the segment schedule.
module tb_dds_seq_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESET_N = 1'b0;
    logic             WR_EN = 1'b0;
    logic [AW-1:0]    WR_ADDR = '0;
    logic [2:0]       WR_FORM = '0;
    logic [31:0]      WR_ADDER = '0;
    logic [CNT_W-1:0] WR_COUNT = '0;
    logic [AW-1:0]    SEG_LAST = '0;
    logic             LOOP = 1'b0;
    logic             START = 1'b0;
    logic             STOP = 1'b0;
    logic             PHASE_WRAP = 1'b0;
    logic [31:0]      ADDER;
    logic [2:0]       FORM;
    logic             UPDATE;
    logic             BUSY;
    logic             DONE;
    logic [AW-1:0]    SEG_IDX;

    dds_seq_ctrl #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_FORM(WR_FORM), .WR_ADDER(WR_ADDER), .WR_COUNT(WR_COUNT),
        .SEG_LAST(SEG_LAST), .LOOP(LOOP), .START(START), .STOP(STOP),
        .PHASE_WRAP(PHASE_WRAP), .ADDER(ADDER), .FORM(FORM), .UPDATE(UPDATE),
        .BUSY(BUSY), .DONE(DONE), .SEG_IDX(SEG_IDX)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // reference table and schedule
    logic [2:0]  m_form [DEPTH];
    logic [31:0] m_adder[DEPTH];
    int          m_cnt  [DEPTH];
    int          slot_seg[$];
    bit          slot_first[$];
    int          pos, sl, n_idle;
    bit          lp, m_done, just_done;
    logic [40:0] exp_v;

    function automatic logic [2:0] fmap(input logic [2:0] f);
        return (f <= 3'd4) ? f : 3'd0;
    endfunction

    function automatic logic [40:0] outs();
        return {ADDER, FORM, SEG_IDX, UPDATE, BUSY, DONE};
    endfunction

    function automatic logic [40:0] ev(input logic [31:0] a, input logic [2:0] f,
                                       input int i, input bit u, input bit b, input bit d);
        logic [AW-1:0] idx;
        idx = i[AW-1:0];
        return {a, f, idx, u, b, d};
    endfunction

    task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [2:0] f, input logic [31:0] ad, input int c);
        WR_ADDR  = a[AW-1:0];
        WR_FORM  = f;
        WR_ADDER = ad;
        WR_COUNT = c[CNT_W-1:0];
        WR_EN    = 1'b1;
        tick();
        WR_EN    = 1'b0;
    endtask

    task automatic wrap();
        PHASE_WRAP = 1'b1;
        tick();
        PHASE_WRAP = 1'b0;
    endtask

    task automatic start(input int last, input bit lpv);
        SEG_LAST = last[AW-1:0];
        LOOP     = lpv;
        START    = 1'b1;
        tick();
        START    = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset_state", outs(), ev(0, 0, 0, 0, 0, 0));
        #10;
        RESET_N = 1'b1;
        tick();

        // two-segment one-shot
        wr(0, 3'b010, 32'h0100_0000, 2);
        wr(1, 3'b011, 32'h0200_0000, 3);
        start(1, 1'b0);
        chk("os_start", outs(), ev(32'h0100_0000, 3'b010, 0, 1, 1, 0));
        tick();
        chk("os_upd_pulse", outs(), ev(32'h0100_0000, 3'b010, 0, 0, 1, 0));
        wrap();
        chk("os_wrap1", outs(), ev(32'h0100_0000, 3'b010, 0, 0, 1, 0));
        wrap();
        chk("os_wrap2", outs(), ev(32'h0200_0000, 3'b011, 1, 1, 1, 0));
        wrap();
        wrap();
        chk("os_wrap4", outs(), ev(32'h0200_0000, 3'b011, 1, 0, 1, 0));
        wrap();
        chk("os_done", outs(), ev(0, 3'b011, 1, 1, 0, 1));
        wrap();
        chk("os_done_hold", outs(), ev(0, 3'b011, 1, 0, 0, 1));

        // looping from DONE
        start(1, 1'b1);
        chk("lp_start", outs(), ev(32'h0100_0000, 3'b010, 0, 1, 1, 0));
        repeat (4) wrap();
        chk("lp_wrap4", outs(), ev(32'h0200_0000, 3'b011, 1, 0, 1, 0));
        wrap();
        chk("lp_wrap5", outs(), ev(32'h0100_0000, 3'b010, 0, 1, 1, 0));
        wrap();

        // write and START while running are ignored
        wr(1, 3'b011, 32'hDEAD_BEEF, 3);
        chk("busy_wr_hold", outs(), ev(32'h0100_0000, 3'b010, 0, 0, 1, 0));
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("busy_start_ign", outs(), ev(32'h0100_0000, 3'b010, 0, 0, 1, 0));
        wrap();
        chk("busy_tbl_kept", outs(), ev(32'h0200_0000, 3'b011, 1, 1, 1, 0));

        // STOP wins over START and PHASE_WRAP
        START = 1'b1; STOP = 1'b1; PHASE_WRAP = 1'b1;
        tick();
        START = 1'b0; STOP = 1'b0; PHASE_WRAP = 1'b0;
        chk("stop_run", outs(), ev(0, 0, 0, 1, 0, 0));
        tick();
        chk("stop_settle", outs(), ev(0, 0, 0, 0, 0, 0));
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        chk("stop_idle_noupd", outs(), ev(0, 0, 0, 0, 0, 0));

        // zero count and reserved form code
        wr(0, 3'b111, 32'h0300_0000, 0);
        start(1, 1'b0);
        chk("zc_start", outs(), ev(32'h0300_0000, 3'b000, 0, 1, 1, 0));
        wrap();
        chk("zc_advance", outs(), ev(32'h0200_0000, 3'b011, 1, 1, 1, 0));

        // asynchronous reset mid-segment clears outputs and table
        wrap();
        RESET_N = 1'b0;
        #2;
        chk("rst_async", outs(), ev(0, 0, 0, 0, 0, 0));
        #2;
        RESET_N = 1'b1;
        tick();
        start(1, 1'b0);
        chk("rst_tbl_clr", outs(), ev(0, 0, 0, 1, 1, 0));

        // randomized tables checked against the expanded period schedule
        for (int it = 0; it < 6; it++) begin
            STOP = 1'b1;
            tick();
            STOP = 1'b0;
            for (int e = 0; e < DEPTH; e++) begin
                m_form[e]  = 3'($urandom_range(0, 7));
                m_adder[e] = $urandom | 32'h8000_0000;
                m_cnt[e]   = $urandom_range(0, 3);
                wr(e, m_form[e], m_adder[e], m_cnt[e]);
            end
            sl = $urandom_range(0, DEPTH - 1);
            lp = 1'($urandom_range(0, 1));
            slot_seg.delete();
            slot_first.delete();
            for (int s = 0; s <= sl; s++) begin
                for (int k = 0; k < ((m_cnt[s] == 0) ? 1 : m_cnt[s]); k++) begin
                    slot_seg.push_back(s);
                    slot_first.push_back(k == 0);
                end
            end
            start(sl, lp);
            pos = 0;
            m_done = 1'b0;
            chk("rnd_start", outs(), ev(m_adder[0], fmap(m_form[0]), 0, 1, 1, 0));
            for (int w = 0; w < 14; w++) begin
                n_idle = $urandom_range(0, 2);
                for (int k = 0; k < n_idle; k++) begin
                    if (!m_done && ($urandom_range(0, 1) == 1))
                        wr($urandom_range(0, DEPTH - 1), 3'($urandom_range(0, 7)), $urandom, 1);
                    else
                        tick();
                    if (m_done)
                        exp_v = ev(0, fmap(m_form[sl]), sl, 0, 0, 1);
                    else
                        exp_v = ev(m_adder[slot_seg[pos]], fmap(m_form[slot_seg[pos]]), slot_seg[pos], 0, 1, 0);
                    chk("rnd_idle", outs(), exp_v);
                end
                wrap();
                just_done = 1'b0;
                if (!m_done) begin
                    pos++;
                    if (pos == slot_seg.size()) begin
                        if (lp) pos = 0;
                        else begin
                            m_done = 1'b1;
                            just_done = 1'b1;
                        end
                    end
                end
                if (m_done)
                    exp_v = ev(0, fmap(m_form[sl]), sl, just_done, 0, 1);
                else
                    exp_v = ev(m_adder[slot_seg[pos]], fmap(m_form[slot_seg[pos]]), slot_seg[pos],
                               slot_first[pos], 1, 0);
                chk("rnd_wrap", outs(), exp_v);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_seq_ctrl.md
Name: dds_seq_ctrl

Overview:
Sequencer that drives the DDS waveform-form block's tuning word (ADDER) and waveform select (form) from a programmable table of segments. Each segment holds a form, a 32-bit tuning word and a duration counted in output periods (phase-accumulator wraps). Segment switches happen only at a phase wrap, so waveforms change on period boundaries. Sits between the host register interface and the DDS accumulator/form datapath.

Parameters:
DEPTH, 8, number of segment table entries (power of 2, >=2)
AW, 3, table address width, equal to log2(DEPTH)
CNT_W, 16, width of the per-segment period count

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
WR_EN  in  1  table write strobe; honoured only when BUSY=0
WR_ADDR  in  AW  table entry index
WR_FORM  in  3  waveform code for the entry
WR_ADDER  in  32  tuning word for the entry
WR_COUNT  in  CNT_W  number of periods for the entry; 0 is treated as 1
SEG_LAST  in  AW  index of the last segment; sampled on START
LOOP  in  1  1 = restart at entry 0 after SEG_LAST; sampled on START
START  in  1  one-cycle start pulse
STOP  in  1  one-cycle abort pulse
PHASE_WRAP  in  1  one-cycle pulse from the DDS accumulator at each period wrap
ADDER  out  32  tuning word to the DDS accumulator
FORM  out  3  waveform select to the form block
UPDATE  out  1  one-cycle strobe when ADDER/FORM change
BUSY  out  1  high in RUN
DONE  out  1  high in DONE state
SEG_IDX  out  AW  index of the active segment

Behaviour:
- Reset (RESET_N low, asynchronous): state IDLE; ADDER=0, FORM=000, UPDATE=0, BUSY=0, DONE=0, SEG_IDX=0; all table entries cleared to zero; latched SEG_LAST/LOOP cleared. Reset asserted mid-run aborts immediately with these values.
- Form codes: 000 saw, 001 reverse saw, 010 triangle, 011 meander, 100 meander 25%. Codes 101..111 are stored as written but driven on FORM as 000.
- Table writes: a write with WR_EN high at edge k is visible from k+1. A write while BUSY=1 is dropped and leaves the table unchanged.
- States: IDLE, RUN, DONE.
- IDLE or DONE, with START=1 and STOP=0 at edge k:
  - state becomes RUN at k+1.
  - SEG_LAST and LOOP are latched.
  - SEG_IDX=0; ADDER/FORM take entry 0; UPDATE=1 for exactly one cycle.
  - The remaining-period counter loads max(count,1).
  - DONE clears.
- RUN, on PHASE_WRAP=1:
  - If remaining>1: decrement remaining.
  - If remaining==1 and SEG_IDX<SEG_LAST: advance to SEG_IDX+1. Load that entry; UPDATE=1 next cycle; reload the counter.
  - If remaining==1 and SEG_IDX==SEG_LAST and LOOP=1: wrap to entry 0 with the same load and UPDATE behaviour.
  - If remaining==1 and SEG_IDX==SEG_LAST and LOOP=0: go to DONE. ADDER=0, FORM holds the last value, SEG_IDX holds, UPDATE=1, DONE=1.
- A single-segment table (SEG_LAST=0) with LOOP=1 reloads entry 0 at each wrap. UPDATE still pulses on each reload.
- RUN with START=1: ignored.
- STOP=1 in any state (STOP wins over a simultaneous START or PHASE_WRAP):
  - next state IDLE; ADDER=0; FORM=000; SEG_IDX=0; DONE=0.
  - UPDATE=1 only if the previous state was RUN or DONE.
- SEG_LAST greater than the number of programmed entries is legal. Unprogrammed entries hold zero, so they play ADDER=0 (output frozen) for 1 period. Because a frozen accumulator produces no further PHASE_WRAP, the sequencer stalls there until STOP or reset.
- Outputs are registered. Latency from START or the deciding PHASE_WRAP edge to new ADDER/FORM is 1 cycle.

Decomposition:
- Shared package dds_pkg holds:
  - form code constants FORM_SAW, FORM_RSAW, FORM_TRI, FORM_MEANDER, FORM_MEANDER25.
  - state enum (IDLE, RUN, DONE).
  - a segment struct {form[2:0], adder[31:0], count[CNT_W-1:0]}.
- One sub-module, dds_seg_table: DEPTH-entry register file with a synchronous write, combinational read, and asynchronous clear on RESET_N.

Test Plan:
- Program entries 0:{010,0x0100_0000,2} and 1:{011,0x0200_0000,3}; SEG_LAST=1, LOOP=0; START. Required response:
  - next cycle: ADDER=0x0100_0000, FORM=010, UPDATE=1.
  - after the 2nd PHASE_WRAP: ADDER=0x0200_0000, FORM=011, SEG_IDX=1.
  - after the 3rd further wrap: DONE=1, ADDER=0, FORM=011.
- Same table with LOOP=1. Required response: after the 5th wrap, SEG_IDX=0 and ADDER=0x0100_0000 with UPDATE=1; BUSY stays 1.
- Entry 0 count=0 and form=111. Required response: FORM drives 000; the segment advances after 1 wrap.
- During RUN, write entry 1 with adder 0xDEAD_BEEF, and pulse START. Required response: the table is unchanged (entry 1 still plays 0x0200_0000) and the sequence is not restarted.
- Assert START, STOP and PHASE_WRAP in the same cycle during RUN. Required response: IDLE next cycle, ADDER=0, FORM=000, UPDATE=1, BUSY=0.
- Drop RESET_N mid-segment. Required response: outputs go to zero immediately; after release, START plays ADDER=0 (table cleared).
